// File: rtl/cc_pkg.sv
// Shared ChaCha20 definitions: FSM encoding, block constants, ARX round
// helpers and the valid-byte mask used by both encrypt and decrypt paths.
package cc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BLOCK = 3'd1,
    S_CRYPT = 3'd2,
    S_TAG   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // 16 state words; word i occupies bits [32*i +: 32]
  typedef logic [15:0][31:0] words_t;

  localparam logic [31:0]  BLK_BYTES = 32'd64;
  localparam logic [511:0] MASK      = {512{1'b1}};

  // "expand 32-byte k" as little-endian words
  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32,
                                        32'h3320646e, 32'h61707865};

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    rotl = (v << n) | (v >> (32 - n));
  endfunction

  // One ChaCha quarter round; result index 0..3 = a, b, c, d
  function automatic logic [3:0][31:0] quarter_round(input logic [31:0] a_in, b_in,
                                                     c_in, d_in);
    logic [31:0] a, b, c, d;
    // NOTE: blocking assignments are intended here: every ARX step must see
    // the value produced by the step before it in the same evaluation.
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    quarter_round = {d, c, b, a};
  endfunction

  // Apply a quarter round to four selected words of the state
  function automatic words_t qr_at(input words_t s, input logic [3:0] ia, ib, ic, id);
    logic [3:0][31:0] q;
    words_t t;
    t = s;
    q = quarter_round(t[ia], t[ib], t[ic], t[id]);
    t[ia] = q[0]; t[ib] = q[1]; t[ic] = q[2]; t[id] = q[3];
    qr_at = t;
  endfunction

  // Column round followed by diagonal round
  function automatic words_t double_round(input words_t s);
    words_t t;
    t = qr_at(s, 4'd0, 4'd4, 4'd8,  4'd12);
    t = qr_at(t, 4'd1, 4'd5, 4'd9,  4'd13);
    t = qr_at(t, 4'd2, 4'd6, 4'd10, 4'd14);
    t = qr_at(t, 4'd3, 4'd7, 4'd11, 4'd15);
    t = qr_at(t, 4'd0, 4'd5, 4'd10, 4'd15);
    t = qr_at(t, 4'd1, 4'd6, 4'd11, 4'd12);
    t = qr_at(t, 4'd2, 4'd7, 4'd8,  4'd13);
    t = qr_at(t, 4'd3, 4'd4, 4'd9,  4'd14);
    double_round = t;
  endfunction

  // Keep the low len bytes of a block (all bytes once len reaches 64)
  function automatic logic [511:0] len_mask(input logic [31:0] len);
    logic [9:0] sh;
    sh = {7'd64 - {1'b0, len[5:0]}, 3'b000};
    if (len >= BLK_BYTES) len_mask = MASK;
    else                  len_mask = MASK >> sh;
  endfunction

endpackage

// File: rtl/cc_block.sv
// ChaCha20 block function: one double round per cycle, ten cycles, then the
// feed-forward addition. o_done pulses with the 512-bit keystream block.
module cc_block
  import cc_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic [255:0] i_key,
  input  logic [95:0]  i_non,
  input  logic [31:0]  i_cnt,
  output logic [511:0] o_stream,
  output logic         o_done
);

  words_t     r_init;
  words_t     r_work;
  words_t     init_w;
  words_t     work_dr;
  words_t     stream_sum;
  logic [3:0] r_round;
  logic       r_run;

  // Assemble the initial state from constants, key, counter and nonce
  always_comb begin
    init_w = '0;
    for (int i = 0; i < 4; i++) init_w[i]      = SIGMA[i];
    for (int i = 0; i < 8; i++) init_w[4 + i]  = i_key[32*i +: 32];
    init_w[12] = i_cnt;
    for (int i = 0; i < 3; i++) init_w[13 + i] = i_non[32*i +: 32];
  end

  assign work_dr = double_round(r_work);

  // Feed-forward: final working state plus the initial state, word-wise
  always_comb begin
    stream_sum = '0;
    for (int i = 0; i < 16; i++) stream_sum[i] = work_dr[i] + r_init[i];
  end

  // Round sequencer: load on start, iterate, emit keystream on the last round
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_init   <= '0;
      r_work   <= '0;
      r_round  <= '0;
      r_run    <= 1'b0;
      o_stream <= '0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        r_init  <= init_w;
        r_work  <= init_w;
        r_round <= '0;
        r_run   <= 1'b1;
      end else if (r_run) begin
        r_work  <= work_dr;
        r_round <= r_round + 4'd1;
        if (r_round == 4'd9) begin
          r_run    <= 1'b0;
          o_stream <= stream_sum;
          o_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cc_decrypt.sv
// ChaCha20 AEAD receive datapath: unmasks ciphertext blocks with keystream
// from cc_block, forwards masked ciphertext to Poly1305, then waits for the
// external tag verdict before signalling completion.
module cc_decrypt
  import cc_pkg::*;
#(
  parameter logic [31:0] CNT_INIT = 32'd1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic         i_en_ct,
  input  logic [255:0] i_key,
  input  logic [95:0]  i_non,
  input  logic [511:0] i_ct,
  input  logic [31:0]  i_len_ct,
  input  logic         i_tag_vld,
  input  logic         i_tag_ok,
  output logic [511:0] o_pt,
  output logic         o_rqst_ct,
  output logic [511:0] o_mac_blk,
  output logic         o_mac_vld,
  output logic         o_auth_ok,
  output logic         o_done,
  output logic         o_busy
);

  state_t       state;
  state_t       state_next;
  logic [511:0] r_ct;
  logic [31:0]  r_len;
  logic [31:0]  r_cnt;
  logic         blk_start;
  logic [31:0]  blk_cnt;
  logic [511:0] blk_stream;
  logic         blk_done;
  logic         load_msg;
  logic         load_next;
  logic         take_tag;
  logic         blk_fin;
  logic [511:0] blk_mask;

  cc_block u_block (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_start  (blk_start),
    .i_key    (i_key),
    .i_non    (i_non),
    .i_cnt    (blk_cnt),
    .o_stream (blk_stream),
    .o_done   (blk_done)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state and control strobes
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    state_next = state;
    blk_start  = 1'b0;
    load_msg   = 1'b0;
    load_next  = 1'b0;
    take_tag   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          load_msg = 1'b1;
          if (i_len_ct != '0) begin
            blk_start  = 1'b1;
            state_next = S_BLOCK;
          end else begin
            state_next = S_TAG;
          end
        end
      end
      S_BLOCK: if (blk_done) state_next = S_CRYPT;
      S_CRYPT: begin
        if (r_len == '0) begin
          state_next = S_TAG;
        end else if (i_en_ct) begin
          load_next  = 1'b1;
          blk_start  = 1'b1;
          state_next = S_BLOCK;
        end
      end
      S_TAG: begin
        if (i_tag_vld) begin
          take_tag   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // First block of a message uses CNT_INIT; later blocks step the counter
  assign blk_cnt  = (state == S_IDLE) ? CNT_INIT : r_cnt + 32'd1;
  assign blk_fin  = (state == S_BLOCK) && blk_done;
  assign blk_mask = len_mask(r_len);

  // Datapath registers and output pulses
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ct      <= '0;
      r_len     <= '0;
      r_cnt     <= CNT_INIT;
      o_pt      <= '0;
      o_mac_blk <= '0;
      o_rqst_ct <= 1'b0;
      o_mac_vld <= 1'b0;
      o_auth_ok <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_rqst_ct <= 1'b0;
      o_mac_vld <= 1'b0;
      o_done    <= 1'b0;
      if (load_msg) begin
        r_ct   <= i_ct;
        r_len  <= i_len_ct;
        o_busy <= 1'b1;
      end
      if (load_next) r_ct  <= i_ct;
      if (blk_start) r_cnt <= blk_cnt;
      if (blk_fin) begin
        o_pt      <= blk_mask & (blk_stream ^ r_ct);
        o_mac_blk <= blk_mask & r_ct;
        o_mac_vld <= 1'b1;
        o_rqst_ct <= (r_len > BLK_BYTES);
        r_len     <= (r_len < BLK_BYTES) ? '0 : r_len - BLK_BYTES;
      end
      if (take_tag) begin
        o_auth_ok <= i_tag_ok;
        o_done    <= 1'b1;
      end
      if (state == S_DONE) o_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cc_decrypt.sv
// Scoreboard bench for cc_decrypt: the driver pushes expected blocks, verdicts
// and counter values; an independent monitor pops and compares them.
module tb_cc_decrypt;

  localparam logic [31:0] CNT_INIT = 32'd1;

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic         i_start = 1'b0;
  logic         i_en_ct = 1'b0;
  logic [255:0] i_key = '0;
  logic [95:0]  i_non = '0;
  logic [511:0] i_ct = '0;
  logic [31:0]  i_len_ct = '0;
  logic         i_tag_vld = 1'b0;
  logic         i_tag_ok = 1'b0;
  logic [511:0] o_pt;
  logic         o_rqst_ct;
  logic [511:0] o_mac_blk;
  logic         o_mac_vld;
  logic         o_auth_ok;
  logic         o_done;
  logic         o_busy;

  cc_decrypt #(.CNT_INIT(CNT_INIT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_en_ct(i_en_ct),
    .i_key(i_key), .i_non(i_non), .i_ct(i_ct), .i_len_ct(i_len_ct),
    .i_tag_vld(i_tag_vld), .i_tag_ok(i_tag_ok), .o_pt(o_pt),
    .o_rqst_ct(o_rqst_ct), .o_mac_blk(o_mac_blk), .o_mac_vld(o_mac_vld),
    .o_auth_ok(o_auth_ok), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [511:0] pt; logic [511:0] mac; logic rqst; } blk_exp_t;
  typedef struct { logic auth; logic [511:0] pt; } done_exp_t;

  blk_exp_t    blk_q [$];
  done_exp_t   done_q [$];
  logic [31:0] cnt_q [$];
  logic [7:0]  msg_pt [$];
  logic [7:0]  msg_ct [$];
  logic [511:0] mdl_last_pt = '0;

  int n_checks = 0;
  int n_err    = 0;

  // RFC 8439 2.4.2 plaintext and ciphertext
  string rfc_pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
  logic [7:0] rfc_ct [0:113] = '{
    8'h6e,8'h2e,8'h35,8'h9a,8'h25,8'h68,8'hf9,8'h80,8'h41,8'hba,8'h07,8'h28,8'hdd,8'h0d,8'h69,8'h81,
    8'he9,8'h7e,8'h7a,8'hec,8'h1d,8'h43,8'h60,8'hc2,8'h0a,8'h27,8'haf,8'hcc,8'hfd,8'h9f,8'hae,8'h0b,
    8'hf9,8'h1b,8'h65,8'hc5,8'h52,8'h47,8'h33,8'hab,8'h8f,8'h59,8'h3d,8'hab,8'hcd,8'h62,8'hb3,8'h57,
    8'h16,8'h39,8'hd6,8'h24,8'he6,8'h51,8'h52,8'hab,8'h8f,8'h53,8'h0c,8'h35,8'h9f,8'h08,8'h61,8'hd8,
    8'h07,8'hca,8'h0d,8'hbf,8'h50,8'h0d,8'h6a,8'h61,8'h56,8'ha3,8'h8e,8'h08,8'h8a,8'h22,8'hb6,8'h5e,
    8'h52,8'hbc,8'h51,8'h4d,8'h16,8'hcc,8'hf8,8'h06,8'h81,8'h8c,8'he9,8'h1a,8'hb7,8'h79,8'h37,8'h36,
    8'h5a,8'hf9,8'h0b,8'hbf,8'h74,8'ha3,8'h5b,8'he6,8'hb4,8'h0b,8'h8e,8'hed,8'hf2,8'h78,8'h5e,8'h42,
    8'h87,8'h4d};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string what);
    n_checks++;
    n_err++;
    $display("FAIL timeout %s: got no event want event", what);
  endtask

  // Reference ChaCha20 block function on plain word arrays
  function automatic int unsigned rotl_m(input int unsigned v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] model_block(input logic [255:0] key,
                                               input logic [95:0] non,
                                               input logic [31:0] cnt);
    int unsigned s [16];
    int unsigned x [16];
    int a, b, c, d;
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = key[32*i +: 32];
    s[12] = cnt;
    for (int i = 0; i < 3; i++) s[13 + i] = non[32*i +: 32];
    x = s;
    for (int rnd = 0; rnd < 20; rnd++) begin
      for (int q = 0; q < 4; q++) begin
        if (rnd % 2 == 0) begin a = q; b = 4 + q; c = 8 + q; d = 12 + q; end
        else begin a = q; b = 4 + (q + 1) % 4; c = 8 + (q + 2) % 4; d = 12 + (q + 3) % 4; end
        x[a] += x[b]; x[d] = rotl_m(x[d] ^ x[a], 16);
        x[c] += x[d]; x[b] = rotl_m(x[b] ^ x[c], 12);
        x[a] += x[b]; x[d] = rotl_m(x[d] ^ x[a], 8);
        x[c] += x[d]; x[b] = rotl_m(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic load_rfc();
    i_key = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    i_non = 96'h000000004a00000000000000;
    msg_pt.delete(); msg_ct.delete();
    for (int i = 0; i < 114; i++) begin
      msg_pt.push_back(8'(rfc_pt[i]));
      msg_ct.push_back(rfc_ct[i]);
    end
  endtask

  task automatic gen_random_msg(input int len);
    logic [511:0] ks;
    logic [7:0] p;
    i_key = {8{$urandom()}};
    i_non = {3{$urandom()}};
    msg_pt.delete(); msg_ct.delete();
    for (int i = 0; i < len; i++) begin
      if (i % 64 == 0) ks = model_block(i_key, i_non, CNT_INIT + 32'(i / 64));
      p = 8'($urandom());
      msg_pt.push_back(p);
      msg_ct.push_back(p ^ ks[8*(i % 64) +: 8]);
    end
  endtask

  task automatic wait_mac(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_mac_vld) begin ok = 1'b1; break; end
    end
  endtask

  task automatic recover();
    i_rstn = 1'b0;
    blk_q.delete(); done_q.delete(); cnt_q.delete();
    mdl_last_pt = '0;
    i_start = 0; i_en_ct = 0; i_tag_vld = 0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  // mode 0: normal; 1: inject ignored strobes; 2: reset during second block
  task automatic run_msg(input int len, input bit tag_ok, input int mode);
    int nblk, cyc, idx, rem;
    bit ok;
    logic [511:0] blks [$];
    logic [511:0] ct, pt, mac;
    nblk = (len + 63) / 64;
    for (int k = 0; k < nblk; k++) begin
      rem = len - 64 * k;
      for (int j = 0; j < 64; j++) begin
        idx = 64 * k + j;
        if (j < rem) begin
          ct[8*j +: 8]  = msg_ct[idx];
          pt[8*j +: 8]  = msg_pt[idx];
          mac[8*j +: 8] = msg_ct[idx];
        end else begin
          ct[8*j +: 8]  = 8'($urandom());
          pt[8*j +: 8]  = 8'h00;
          mac[8*j +: 8] = 8'h00;
        end
      end
      blks.push_back(ct);
      blk_q.push_back('{pt: pt, mac: mac, rqst: (rem > 64)});
      cnt_q.push_back(CNT_INIT + 32'(k));
      mdl_last_pt = pt;
    end
    done_q.push_back('{auth: tag_ok, pt: mdl_last_pt});

    @(negedge i_clk);
    i_ct = (nblk > 0) ? blks[0] : {16{$urandom()}};
    i_len_ct = 32'(len);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    if (mode == 1 && nblk > 0) begin
      i_start = 1'b1; i_len_ct = 32'd5; i_ct = {16{$urandom()}}; i_en_ct = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0; i_en_ct = 1'b0;
    end

    for (int k = 1; k < nblk; k++) begin
      wait_mac(ok);
      if (!ok) begin timeout_fail("rqst_ct"); recover(); return; end
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      i_ct = blks[k];
      i_en_ct = 1'b1;
      if (mode == 1) begin i_tag_vld = 1'b1; i_tag_ok = ~tag_ok; end
      @(negedge i_clk);
      i_en_ct = 1'b0; i_tag_vld = 1'b0;
      if (mode == 2 && k == 1) begin
        repeat (3) @(negedge i_clk);
        i_rstn = 1'b0;
        #1;
        check("rst_pt", o_pt, '0);
        check("rst_mac_blk", o_mac_blk, '0);
        check("rst_rqst", o_rqst_ct, 0);
        check("rst_mac_vld", o_mac_vld, 0);
        check("rst_auth", o_auth_ok, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        recover();
        return;
      end
    end

    if (nblk > 0) begin
      wait_mac(ok);
      if (!ok) begin timeout_fail("last_block"); recover(); return; end
      @(negedge i_clk);
    end
    repeat ($urandom_range(0, 2)) @(negedge i_clk);
    i_tag_vld = 1'b1;
    i_tag_ok = tag_ok;
    @(negedge i_clk);
    i_tag_vld = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 20) begin @(negedge i_clk); cyc++; end
    if (!o_done) begin timeout_fail("done"); recover(); return; end
    if (len == 0) check("len0_done_latency_le2", (cyc <= 1), 1);
    @(negedge i_clk);
    check("busy_after_done", o_busy, 0);
    check("done_single_pulse", o_done, 0);
  endtask

  // Monitor: compares every DUT event against the scoreboard queues
  initial begin
    blk_exp_t  eb;
    done_exp_t ed;
    forever begin
      @(negedge i_clk);
      #1;
      if (i_rstn) begin
        if (dut.u_block.i_start) begin
          if (cnt_q.size() == 0) check("unexpected_blk_start", 1, 0);
          else check("blk_cnt", dut.u_block.i_cnt, cnt_q.pop_front());
        end
        if (o_mac_vld) begin
          if (blk_q.size() == 0) check("unexpected_mac_vld", 1, 0);
          else begin
            eb = blk_q.pop_front();
            check("pt", o_pt, eb.pt);
            check("mac_blk", o_mac_blk, eb.mac);
            check("rqst_ct", o_rqst_ct, eb.rqst);
          end
        end else if (o_rqst_ct) begin
          check("rqst_without_mac", 1, 0);
        end
        if (o_done) begin
          if (done_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            ed = done_q.pop_front();
            check("auth_ok", o_auth_ok, ed.auth);
            check("pt_at_done", o_pt, ed.pt);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int lens [6] = '{63, 64, 65, 1, 191, 200};
    repeat (3) @(negedge i_clk);
    check("reset_pt", o_pt, '0);
    check("reset_mac_blk", o_mac_blk, '0);
    check("reset_rqst", o_rqst_ct, 0);
    check("reset_mac_vld", o_mac_vld, 0);
    check("reset_auth", o_auth_ok, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    load_rfc();         run_msg(114, 1'b1, 0);
    load_rfc();         run_msg(114, 1'b0, 0);
    gen_random_msg(128); run_msg(128, 1'b1, 0);
    gen_random_msg(0);   run_msg(0, 1'b1, 0);
    load_rfc();         run_msg(114, 1'b1, 1);
    load_rfc();         run_msg(114, 1'b1, 2);
    load_rfc();         run_msg(114, 1'b1, 0);
    foreach (lens[i]) begin
      gen_random_msg(lens[i]);
      run_msg(lens[i], 1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge i_clk);
    check("blk_q_drained", blk_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("cnt_q_drained", cnt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cc_decrypt.md
Name: cc_decrypt

Overview:
ChaCha20 decryption engine for the AEAD receive path: the counterpart of the encrypt datapath. It consumes 64-byte ciphertext blocks, generates the keystream through a cc_block instance, and returns masked plaintext. Each masked ciphertext block is forwarded to the Poly1305 MAC. The final result is held until the external tag comparison reports, so the caller receives plaintext plus a pass/fail verdict.

Parameters:
CNT_INIT, 32'd1, block counter value for the first ciphertext block (block 0 is reserved for the Poly1305 key)

Ports:
i_clk  input  1  clock; single clock domain
i_rstn  input  1  reset; asynchronous, active-low
i_start  input  1  start pulse; latches i_ct and i_len_ct; ignored while o_busy=1
i_en_ct  input  1  next-ciphertext-block strobe; honoured only in CRYPT state
i_key  input  256  key; must stay stable while o_busy=1
i_non  input  96  nonce; must stay stable while o_busy=1
i_ct  input  512  ciphertext block; byte 0 in bits [7:0]
i_len_ct  input  32  total ciphertext length in bytes
i_tag_vld  input  1  tag comparison result valid; honoured only in TAG state
i_tag_ok  input  1  1 = computed tag matches received tag
o_pt  output  512  plaintext block, masked to the valid bytes
o_rqst_ct  output  1  1-cycle pulse: o_pt is valid and the next ciphertext block is requested
o_mac_blk  output  512  masked ciphertext block for Poly1305
o_mac_vld  output  1  1-cycle pulse qualifying o_mac_blk
o_auth_ok  output  1  verdict; valid while o_done=1
o_done  output  1  1-cycle pulse; last o_pt and o_auth_ok are valid
o_busy  output  1  block is processing a message

Behaviour:
- Reset values: o_pt=0, o_mac_blk=0, o_rqst_ct=0, o_mac_vld=0, o_auth_ok=0, o_busy=0, o_done=0. FSM resets to IDLE, counter to CNT_INIT, length to 0.
- FSM states: IDLE, BLOCK, CRYPT, TAG, DONE.
- IDLE:
  - i_start with i_len_ct!=0: assert the cc_block start the same cycle and go to BLOCK.
  - i_start with i_len_ct==0: go to TAG; no keystream and no MAC pulse.
- BLOCK: wait for the cc_block done pulse (blk_done), then go to CRYPT.
- On the blk_done edge:
  - o_pt <= mask & (stream ^ r_ct).
  - o_mac_blk <= mask & r_ct; o_mac_vld=1 for one cycle.
  - mask = all-ones if r_len>=64, else all-ones >> ((64-r_len)*8).
  - r_len <= (r_len<64) ? 0 : r_len-64.
  - o_rqst_ct=1 for one cycle only if r_len>64 before the update. An exact multiple of 64 produces no request on the last block.
- CRYPT:
  - r_len==0: go to TAG.
  - Otherwise, i_en_ct: latch i_ct, counter += 1, start cc_block the same cycle, go to BLOCK.
  - Otherwise, hold.
- TAG: on i_tag_vld, latch o_auth_ok <= i_tag_ok and go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_busy clears on the cycle after DONE.
- o_busy: set on the cycle after an accepted i_start.
- o_pt is released before authentication. Downstream must discard the message when o_auth_ok=0; this block does not clear o_pt on failure.
- Counter: 32-bit and wraps silently. Message length is bounded by i_len_ct, which is the caller's responsibility.
- Ignored strobes: i_en_ct outside CRYPT, i_tag_vld outside TAG, and i_start while busy. None of these change any state.
- Simultaneous events: i_en_ct and i_tag_vld both high in CRYPT: only i_en_ct is acted on.
- Reset mid-operation: all registers and the cc_block instance return to reset values immediately; no o_done is produced.
- Latency per block: cc_block latency + 1 cycle from start to o_rqst_ct/o_mac_vld.

Decomposition:
- Shared package cc_pkg:
  - FSM state encoding (3-bit).
  - BLK_BYTES=64.
  - 512-bit all-ones MASK.
  - Mask-generation function (shared with the encrypt path).
- Sub-module: reuse the existing cc_block (key, nonce, counter -> 512-bit stream, done pulse) unchanged; no new sub-module.

Test Plan:
- RFC 8439 §2.4.2 vector decrypted: key 00..1f, nonce 000000000000004a00000000, CNT_INIT=1, len=114, two ciphertext blocks, then i_tag_vld with i_tag_ok=1.
  - Required: o_pt = "Ladies and Gentlemen of the class of '99..." (64 then 50 bytes); second o_pt bits [511:400]=0; one o_rqst_ct; two o_mac_vld; o_done with o_auth_ok=1.
- Same vector with i_tag_ok=0 -> identical o_pt stream, o_done with o_auth_ok=0.
- len=128 -> exactly one o_rqst_ct; no third block started; FSM goes CRYPT->TAG after the second block.
- len=0 -> no cc_block start and no o_mac_vld; after i_tag_vld, o_done in ≤2 cycles with o_busy falling.
- Negative cases:
  - i_start pulse mid-message: ignored.
  - i_en_ct asserted during BLOCK: ignored; counter unchanged (check cc_block i_cnt = 1, 2 only).
- Assert i_rstn=0 during the second BLOCK -> all outputs 0 next cycle; a fresh i_start with the §2.4.2 vector reproduces the correct plaintext.
